// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults and frame-length helper for the I2S transmitter
package i2s_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CLK_DIV_DEF = 14;
  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction
endpackage

// File: rtl/i2s_if.sv
// i2s_if: sample input and serial pin bundle of the I2S transmitter
interface i2s_if import i2s_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic in_valid;
  logic mute;
  logic frame_strobe;
  logic underrun;
  logic i2s_bck;
  logic i2s_lrck;
  logic i2s_data;
  modport master (
    output left, right, in_valid, mute,
    input frame_strobe, underrun, i2s_bck, i2s_lrck, i2s_data
  );
  modport slave (
    input left, right, in_valid, mute,
    output frame_strobe, underrun, i2s_bck, i2s_lrck, i2s_data
  );
endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: integer divider producing BCK and edge ticks aligned with its toggles
module i2s_clkgen import i2s_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  output logic i2s_bck,
  output logic fall_tick,
  output logic rise_tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic wrap;
  assign wrap = div_cnt == DW'(CLK_DIV - 1);
  assign fall_tick = wrap & i2s_bck;
  assign rise_tick = wrap & ~i2s_bck;
  // count one BCK half-period, toggling BCK on the last count
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt <= '0;
      i2s_bck <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) i2s_bck <= ~i2s_bck;
    end
  end
endmodule

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: holds the latest stereo pair and shifts it out in Philips I2S format
module i2s_audio_tx import i2s_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input logic clk_sys,
  input logic reset,
  i2s_if.slave bus
);
  localparam int FL = frame_len(WIDTH);
  localparam int BW = $clog2(FL);
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [WIDTH-1:0] hold_l, hold_r;
  logic [FL-1:0] sh, frame;
  logic fresh, fall_tick, load;
  i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_sys(clk_sys),
    .reset(reset),
    .i2s_bck(bus.i2s_bck),
    .fall_tick(fall_tick),
    .rise_tick()
  );
  // next bit position, frame-load condition and the word to load
  always_comb begin
    bit_nxt = bit_cnt == BW'(FL - 1) ? '0 : bit_cnt + 1'b1;
    load = fall_tick && bit_cnt == BW'(FL - 1);
    frame = bus.mute ? '0 : {hold_l, hold_r};
  end
  // holding registers, frame shifter and registered pin outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= BW'(FL - 1);
      sh <= '0;
      hold_l <= '0;
      hold_r <= '0;
      fresh <= 1'b0;
      bus.i2s_lrck <= 1'b0;
      bus.i2s_data <= 1'b0;
      bus.frame_strobe <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      bus.frame_strobe <= load;
      bus.underrun <= load & ~fresh;
      fresh <= bus.in_valid | (fresh & ~load);
      if (bus.in_valid) begin
        hold_l <= bus.left;
        hold_r <= bus.right;
      end
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        bus.i2s_lrck <= bit_nxt >= BW'(WIDTH - 1) && bit_nxt <= BW'(FL - 2);
        bus.i2s_data <= load ? frame[FL-1] : sh[FL-1];
        sh <= load ? frame << 1 : sh << 1;
      end
    end
  end
endmodule

// File: doc/i2s_audio_tx.md
# i2s_audio_tx

Serial audio transmitter between the TGFX16 core's parallel stereo PCM output and the board's I2S DAC pins (I2S_BCK, I2S_LRCK, I2S_DATA). It holds the latest left/right sample pair, derives BCK and LRCK from the system clock with an integer divider, and shifts samples out MSB-first in standard Philips I2S format. It runs in the core clock domain and drives the pins directly.

## Interface

Parameters:
- WIDTH, 16, bits per channel slot. Sample width equals slot width; a frame is 2*WIDTH BCK periods.
- CLK_DIV, 14, clk_sys cycles per BCK half-period; legal range is CLK_DIV >= 1.

Ports:
- clk_sys  in  1  core system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- left  in  WIDTH  left sample, two's complement, passed to the DAC unmodified.
- right  in  WIDTH  right sample, two's complement.
- in_valid  in  1  single-cycle qualifier; captures left/right into the holding registers.
- mute  in  1  sampled at each frame load; when high, the frame transmits zeros.
- frame_strobe  out  1  one-cycle pulse when a new frame is loaded into the shifter.
- underrun  out  1  one-cycle pulse, coincident with frame_strobe, when no in_valid arrived since the previous load.
- i2s_bck  out  1  bit clock.
- i2s_lrck  out  1  word select: 0 = left, 1 = right.
- i2s_data  out  1  serial data.

## Operation

- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. On the edge where div_cnt == CLK_DIV-1, i2s_bck toggles.
- Bit counter: bit_cnt ranges 0..2*WIDTH-1 and advances only on BCK falling toggles (1->0), wrapping 2*WIDTH-1 -> 0. All i2s_lrck and i2s_data changes occur on that same clk_sys edge.
- LRCK: i2s_lrck = 1 iff bit_cnt is in WIDTH-1 .. 2*WIDTH-2, otherwise 0. LRCK therefore changes one BCK before each channel's MSB, which gives the I2S one-bit delay.
- Data:
  - bit_cnt k < WIDTH: i2s_data = left_sh[WIDTH-1-k].
  - k >= WIDTH: i2s_data = right_sh[2*WIDTH-1-k].
- Frame load: on the falling toggle where bit_cnt wraps to 0:
  - left_sh and right_sh load from the holding registers, or all zeros if mute = 1.
  - frame_strobe pulses.
  - underrun pulses if the fresh flag is 0.
  - fresh is cleared.
- Holding: when in_valid = 1, hold_l/hold_r capture left/right and fresh is set.
  - If in_valid coincides with a frame load, the load uses the pre-edge holding contents. The new sample waits for the next frame, and fresh ends set (the set wins over the clear).
  - Back-to-back in_valid overwrites; only the last pair before a load is sent.
- Underrun behaviour: the previous holding pair is repeated, not zeroed.
- Reset values:
  - Outputs: i2s_bck = 0, i2s_lrck = 0, i2s_data = 0, frame_strobe = 0, underrun = 0.
  - Internal: div_cnt = 0, bit_cnt = 2*WIDTH-1, shifters, holding registers and fresh all 0.
  - Reset asserted mid-frame aborts the frame immediately. The next cycle shows the reset values and no partial word continues.

## Timing

- After reset deasserts (cycle 0 = first cycle with reset low):
  - i2s_bck rises at the edge ending cycle CLK_DIV-1.
  - i2s_bck falls at the edge ending cycle 2*CLK_DIV-1.
  - The first frame load happens on that fall.
- Period rules: BCK period = 2*CLK_DIV clk_sys cycles; frame period = 4*WIDTH*CLK_DIV cycles. Defaults at 42.95 MHz give about 47.9 kHz.
- Latency: in_valid to MSB on pin is at most one frame period plus 2*CLK_DIV cycles. The minimum is 1 cycle, when in_valid lands one cycle before a load.
- DAC timing: data and LRCK are stable for a full BCK period centred on the BCK rising edge, where the DAC samples.
- All outputs are registered; no combinational path from inputs to pins.

## Structure

- i2s_pkg:
  - Default WIDTH and CLK_DIV.
  - A localparam function for frame length (2*WIDTH).
- Sub-module i2s_clkgen: contains div_cnt and bck. Outputs i2s_bck plus one-cycle fall_tick/rise_tick pulses aligned with the toggle edge. i2s_audio_tx consumes fall_tick only.
- Top-level instantiation sits beside the core inside the shared top. The left/right sample outputs of the core feed it, and its pins map to I2S_BCK/I2S_LRCK/I2S_DATA.

## Test plan

- Reset then idle, CLK_DIV=2, WIDTH=16:
  - BCK period is 4 cycles and the first fall occurs 4 cycles after reset release.
  - frame_strobe and underrun pulse together on that fall; data stays 0.
- Serial format: in_valid with left=16'hA5C3, right=16'h8001 before a load.
  - The next frame shifts 1010010111000011 while LRCK=0, then 1000000000000001 while LRCK=1.
  - LRCK changes exactly one BCK before each MSB.
- Coincident in_valid at a load edge: the in_valid pair 16'h1234/16'h5678 arrives on the load edge while holding=16'h1111/16'h2222.
  - The current frame sends 1111/2222.
  - The next frame sends 1234/5678 with no underrun pulse.
- Underrun repeat: no in_valid for 3 frames after loading 16'h7FFF/16'h8000.
  - Three identical frames are sent, each with an underrun pulse.
- Mute: mute=1 at a load with holding 16'hFFFF/16'hFFFF.
  - The frame is all zeros.
  - Releasing mute mid-frame does not change the frame; the next frame sends FFFF.
- Reset mid-frame at bit_cnt=20: all outputs return to their reset values the next cycle, and the first post-reset frame restarts from the left MSB at the exact cycle count defined above.
